// File: rtl/emesh_pkt_fifo_if.sv
// rtl/emesh_pkt_fifo_if.sv - emesh packet handshake bundle for emesh_pkt_fifo
// slave is the buffer's view; master is the producer/consumer side.
interface emesh_pkt_fifo_if #(
  parameter int PW = 104
);
  logic          in_access;
  logic [PW-1:0] in_packet;
  logic          in_wait;
  logic          out_access;
  logic [PW-1:0] out_packet;
  logic          out_wait;
  logic          overflow;
  logic [7:0]    drop_count;

  modport slave (
    input  in_access, in_packet, out_wait,
    output in_wait, out_access, out_packet, overflow, drop_count
  );

  modport master (
    output in_access, in_packet, out_wait,
    input  in_wait, out_access, out_packet, overflow, drop_count
  );
endinterface

// File: rtl/emesh_pkt_fifo.sv
// rtl/emesh_pkt_fifo.sv - emesh packet buffer with registered output, bypass and sticky overflow
// Define EMESH_FIFO_STATS_EN to build the saturating drop_count counter.
module emesh_pkt_fifo #(
  parameter int PW     = 104,
  parameter int DEPTH  = 16,
  parameter int MARGIN = 4
) (
  input  logic             sys_clk,
  input  logic             sys_nreset,
  emesh_pkt_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] count, count_next;
  logic [CW:0]   occ_next;

  logic push, pop, load, mem_rd, bypass, wr_req, mem_wr, drop;
  logic out_access_next;

  always_comb begin
    push            = bus.in_access;
    pop             = bus.out_access && !bus.out_wait;
    load            = !bus.out_access || pop;
    mem_rd          = 1'b0;
    bypass          = 1'b0;
    out_access_next = bus.out_access;
    if (load) begin
      mem_rd          = (count != '0);
      bypass          = (count == '0) && push;
      out_access_next = mem_rd || bypass;
    end
    wr_req     = push && !bypass;
    mem_wr     = wr_req && ((count < CW'(DEPTH)) || mem_rd);
    drop       = wr_req && !mem_wr;
    count_next = count + CW'(mem_wr) - CW'(mem_rd);
    // Occupancy for pushback includes the output register.
    occ_next   = {1'b0, count_next} + (CW+1)'(out_access_next);
  end

  always_ff @(posedge sys_clk) begin
    if (mem_wr) mem[wptr] <= bus.in_packet;
  end

  always_ff @(posedge sys_clk or negedge sys_nreset) begin
    if (!sys_nreset) begin
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      bus.out_access <= 1'b0;
      bus.out_packet <= '0;
      bus.in_wait    <= 1'b0;
      bus.overflow   <= 1'b0;
    end else begin
      count          <= count_next;
      bus.out_access <= out_access_next;
      bus.in_wait    <= (occ_next >= (CW+1)'(DEPTH - MARGIN));
      if (mem_wr) wptr <= wptr + 1'b1;
      if (mem_rd) begin
        rptr           <= rptr + 1'b1;
        bus.out_packet <= mem[rptr];
      end else if (bypass) begin
        bus.out_packet <= bus.in_packet;
      end
      if (drop) bus.overflow <= 1'b1;
    end
  end

`ifdef EMESH_FIFO_STATS_EN
  logic [7:0] drop_cnt;

  always_ff @(posedge sys_clk or negedge sys_nreset) begin
    if (!sys_nreset) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign bus.drop_count = drop_cnt;
`else
  assign bus.drop_count = 8'd0;
`endif
endmodule
